// File: rtl/sb_cfg_pkg.sv
// Shared constants and sizing helpers for the sb_cfg_xbar routing block.
// SB_CFG_XBAR_PARITY_EN adds a leading even-parity bit to the configuration chain.
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_ACCEPT,
    CMT_REJECT
  } commit_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned mux_in);
    return clog2(mux_in);
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned chan_w, input int unsigned mux_in);
    return chan_w * sel_width(mux_in);
  endfunction

  // The parity bit sits ahead of the payload, so it ends up at the chain MSB.
  function automatic int unsigned chain_len(input int unsigned payload_bits);
`ifdef SB_CFG_XBAR_PARITY_EN
    return payload_bits + 1;
`else
    return payload_bits;
`endif
  endfunction

endpackage

// File: rtl/sb_cfg_xbar_if.sv
// Configuration-chain interface of sb_cfg_xbar: serial load, commit request and status.
interface sb_cfg_xbar_if;

  logic ccff_head;
  logic ccff_shift_en;
  logic ccff_commit;
  logic ccff_tail;
  logic cfg_loaded;
  logic cfg_active;
  logic cfg_err;

  modport master (
    output ccff_head, ccff_shift_en, ccff_commit,
    input  ccff_tail, cfg_loaded, cfg_active, cfg_err
  );

  modport slave (
    input  ccff_head, ccff_shift_en, ccff_commit,
    output ccff_tail, cfg_loaded, cfg_active, cfg_err
  );

endinterface

// File: rtl/sb_cfg_mux.sv
// One MUX_IN:1 track selector; out-of-range selects and a disabled selector drive 0.
import sb_cfg_pkg::*;

module sb_cfg_mux #(
  parameter int unsigned MUX_IN = 8
) (
  input  logic [MUX_IN-1:0]            data,
  input  logic [sel_width(MUX_IN)-1:0] sel,
  input  logic                         en,
  output logic                         y
);

  always_comb begin
    y = 1'b0;
    if (en && (32'(sel) < MUX_IN)) begin
      y = data[sel];
    end
  end

endmodule

// File: rtl/sb_cfg_xbar.sv
// Parametrised routing switch block with a double-buffered serial configuration chain.
// Build with SB_CFG_XBAR_PARITY_EN to require even parity over the chain before a commit.
import sb_cfg_pkg::*;

module sb_cfg_xbar #(
  parameter int unsigned CHAN_W = 9,
  parameter int unsigned MUX_IN = 8
) (
  input  logic                       prog_clk,
  input  logic                       pReset,
  sb_cfg_xbar_if.slave               cfg,
  input  logic [CHAN_W*MUX_IN-1:0]   mux_in,
  output logic [CHAN_W-1:0]          chan_out
);

  localparam int unsigned SEL_W    = sel_width(MUX_IN);
  localparam int unsigned CFG_BITS = cfg_bits(CHAN_W, MUX_IN);
  localparam int unsigned LEN      = chain_len(CFG_BITS);
  localparam int unsigned CNT_W    = clog2(LEN + 1);

  logic [LEN-1:0]      shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    count;
  logic                tail_q;
  logic                active_q;
  logic                err_q;
  logic                loaded;
  logic                parity_ok;
  commit_e             cmt;

  assign loaded = (count == CNT_W'(LEN));

`ifdef SB_CFG_XBAR_PARITY_EN
  assign parity_ok = ~(^shadow);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    cmt = CMT_NONE;
    if (cfg.ccff_commit) begin
      cmt = (loaded && !cfg.ccff_shift_en && parity_ok) ? CMT_ACCEPT : CMT_REJECT;
    end
  end

  // An accepted commit never coincides with a shift, so count has one writer per edge.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow   <= '0;
      active   <= '0;
      count    <= '0;
      tail_q   <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cfg.ccff_shift_en) begin
        shadow <= {shadow[LEN-2:0], cfg.ccff_head};
        tail_q <= shadow[LEN-1];
        if (!loaded) begin
          count <= count + 1'b1;
        end
      end
      case (cmt)
        CMT_ACCEPT: begin
          active   <= shadow[CFG_BITS-1:0];
          count    <= '0;
          active_q <= 1'b1;
        end
        CMT_REJECT: err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign cfg.ccff_tail  = tail_q;
  assign cfg.cfg_loaded = loaded;
  assign cfg.cfg_active = active_q;
  assign cfg.cfg_err    = err_q;

  for (genvar k = 0; k < CHAN_W; k++) begin : g_mux
    sb_cfg_mux #(
      .MUX_IN(MUX_IN)
    ) u_mux (
      .data (mux_in[k*MUX_IN +: MUX_IN]),
      .sel  (active[k*SEL_W +: SEL_W]),
      .en   (active_q),
      .y    (chan_out[k])
    );
  end

endmodule

// File: doc/sb_cfg_xbar.md
Name: sb_cfg_xbar

Overview:
- Parametrised successor to the fixed-size routing switch blocks.
- Holds CHAN_W output tracks. Each track is driven by a MUX_IN:1 selector from a flat candidate bus.
- Selectors are programmed through the standard configuration chain (ccff_head/ccff_tail).
- Adds a double-buffered shadow/active register, a shift counter and a commit handshake, so routing never glitches while the chain is shifting.

Parameters:
- CHAN_W, 9, number of output tracks (one mux each).
- MUX_IN, 8, inputs per mux; must be at least 2.
- SEL_W, clog2(MUX_IN), select bits per mux; derived localparam, not overridable.
- CFG_BITS, CHAN_W*SEL_W, payload chain length; derived localparam.

Ports:
- prog_clk  in  1  configuration/operation clock; the only clock.
- pReset  in  1  reset, asynchronous, active-high; clears all state.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift one chain bit this cycle.
- ccff_commit  in  1  single-cycle request to copy shadow to active.
- mux_in  in  CHAN_W*MUX_IN  candidate inputs; mux k uses slice [k*MUX_IN +: MUX_IN].
- chan_out  out  CHAN_W  routed tracks.
- ccff_tail  out  1  serial data out; the last chain bit.
- cfg_loaded  out  1  shift count has reached the chain length.
- cfg_active  out  1  at least one commit has been accepted since reset.
- cfg_err  out  1  sticky flag for a rejected commit.

Behaviour:
- Reset (pReset=1, asynchronous): shadow=0, active=0, shift count=0; cfg_loaded, cfg_active and cfg_err are all 0. chan_out=0 and ccff_tail=0. A reset in mid-shift discards the partial load.
- Shift (ccff_shift_en=1 at a prog_clk rising edge):
  - shadow <= {shadow[LEN-2:0], ccff_head}, where LEN is the chain length.
  - ccff_tail = shadow[LEN-1] (registered).
  - The count increments and saturates at LEN. cfg_loaded = (count==LEN).
  - Bits beyond LEN keep shifting through to ccff_tail; the count stays at LEN.
- Mux k select = active[k*SEL_W +: SEL_W]. The first bit shifted in lands in the MSB of mux CHAN_W-1.
- Commit is accepted when ccff_commit=1, cfg_loaded=1 and ccff_shift_en=0. On acceptance, at that edge:
  - active <= shadow payload;
  - count <= 0;
  - cfg_active <= 1.
  - The new selections drive chan_out combinationally from the following cycle. Total latency is 1 prog_clk.
- Commit is rejected (no state change except cfg_err <= 1) in either case:
  - cfg_loaded=0;
  - ccff_shift_en=1 in the same cycle.
- cfg_err is sticky until pReset.
- chan_out[k]:
  - Equals mux_in[k*MUX_IN + sel_k] when cfg_active=1 and sel_k < MUX_IN.
  - Equals 0 when sel_k >= MUX_IN (non-power-of-2 MUX_IN).
  - Equals 0 when cfg_active=0.
  - Combinational from mux_in; no added register on the data path.
- Shifting after a commit leaves active and chan_out unchanged until the next accepted commit.
- ccff_commit held high for several cycles: each qualifying edge is evaluated independently. After an accepted commit the count is 0, so the next edge is rejected and sets cfg_err.

Optional Feature:
- Macro: SB_CFG_XBAR_PARITY_EN.
- Defined:
  - Chain length LEN = CFG_BITS+1. The first bit shifted in is an even-parity bit and ends at shadow[LEN-1].
  - A commit also requires XOR of all LEN shadow bits == 0.
  - On a parity mismatch the commit is rejected and cfg_err <= 1; active is unchanged and the count is kept.
- Undefined: LEN = CFG_BITS and no parity check is made.

Decomposition:
- Package sb_cfg_pkg holds:
  - the clog2 constant function;
  - the SEL_W/CFG_BITS derivation helpers;
  - the parity-enable LEN computation.
- Sub-module sb_cfg_mux: a single parametrised MUX_IN:1 selector with out-of-range output forced to 0, instantiated CHAN_W times via generate.
- The counter, shadow/active registers and commit logic stay in the top module.

Test Plan (defaults CHAN_W=9, MUX_IN=8, SEL_W=3, CFG_BITS=27, parity off):
- Reset release, no shifts, mux_in all ones -> chan_out=9'h000, cfg_active=0, ccff_tail=0.
- Shift 27 bits forming select 5 for every mux, then commit; set mux_in bits k*8+5 to 1 and all others to 0 -> cfg_loaded=1 before the commit; after the commit chan_out=9'h1FF, cfg_active=1, cfg_err=0.
- Shift only 26 bits, then commit -> cfg_err=1, chan_out unchanged, count stays 26. One more shift sets cfg_loaded=1.
- Shift 28 bits with the first bit=1 -> ccff_tail=1 after the 28th edge and cfg_loaded stays 1. Assert ccff_commit and ccff_shift_en together -> rejected, cfg_err=1.
- Commit config A, then shift config B without committing -> chan_out follows A throughout. Assert pReset mid-shift of B -> all outputs 0 at once, asynchronously.
- Parity on, 28 bits with a wrong parity bit -> commit rejected, cfg_err=1. Reload with the correct parity -> accepted, chan_out matches the decoded selects.
